// File: rtl/tcdm_pkg.sv
// tcdm_pkg: shared types and limits for the TCDM-to-SRAM response path
//   RD_LATENCY_MAX  : deepest supported grant-to-r_valid latency
//   TCDM_DATA_WIDTH : default bus data width
//   resp_stage_t    : one response-pipeline stage {valid, is_read, rdata}
package tcdm_pkg;

    localparam int RD_LATENCY_MAX  = 4;
    localparam int TCDM_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       valid;
        logic                       is_read;
        logic [TCDM_DATA_WIDTH-1:0] rdata;
    } resp_stage_t;

endpackage

// File: rtl/tcdm_resp_pipe.sv
// tcdm_resp_pipe: reset-clearable valid/data delay line of DEPTH cycles from access to response
//   clk_i, rst_ni     : clock, async active-low reset (empties the line)
//   acc_valid         : an SRAM access is issued this cycle
//   acc_read          : that access is a read
//   rdata             : SRAM read data, valid the cycle after a read access
//   resp              : response stage DEPTH cycles after the access
module tcdm_resp_pipe
    import tcdm_pkg::*;
#(
    parameter int  DEPTH      = 1,
    parameter type stage_t    = resp_stage_t,
    parameter int  DATA_WIDTH = $bits(stage_t) - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  acc_valid,
    input  logic                  acc_read,
    input  logic [DATA_WIDTH-1:0] rdata,
    output stage_t                resp
);

    logic   s0_valid;
    logic   s0_read;
    stage_t head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_valid <= 1'b0;
            s0_read  <= 1'b0;
        end else begin
            s0_valid <= acc_valid;
            s0_read  <= acc_valid & acc_read;
        end
    end

    // Macro data joins the control bits one cycle after the access; writes and
    // idle slots carry zero so downstream stages never toggle on garbage.
    always_comb begin
        head         = '0;
        head.valid   = s0_valid;
        head.is_read = s0_read;
        head.rdata   = s0_read ? rdata : '0;
    end

    if (DEPTH == 1) begin : g_direct
        assign resp = head;
    end else begin : g_dly
        stage_t dly [DEPTH-1];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH - 1; i++) dly[i] <= '0;
            end else begin
                dly[0] <= head;
                for (int i = 1; i < DEPTH - 1; i++) dly[i] <= dly[i-1];
            end
        end
        assign resp = dly[DEPTH-2];
    end

endmodule

// File: rtl/tcdm_sram_bridge.sv
// tcdm_sram_bridge: terminal TCDM slave driving one single-port SRAM macro, fixed-latency responses
//   clk_i, rst_ni      : clock, async active-low reset
//   tcdm_req/add/wen/wdata/be : TCDM request (wen=1 read, wen=0 write)
//   tcdm_gnt           : combinational grant = req & sram_ready_i
//   tcdm_r_valid/r_rdata : one response per grant, RD_LATENCY cycles later
//   sram_ready_i       : macro available
//   sram_req_o/we_o/addr_o/wdata_o/be_o : macro access, all zero when not granted
//   sram_rdata_i       : macro read data, one cycle after a read access
//   oor_o              : sticky, a granted access had address bits above the SRAM range
// Build option TCDM_SRAM_BRIDGE_RDATA_HOLD_EN: r_rdata holds the last read data
// instead of returning to zero between read responses.
module tcdm_sram_bridge
    import tcdm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SRAM_AW    = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    tcdm_req,
    input  logic [ADDR_WIDTH-1:0]   tcdm_add,
    input  logic                    tcdm_wen,
    input  logic [DATA_WIDTH-1:0]   tcdm_wdata,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be,
    output logic                    tcdm_gnt,
    output logic                    tcdm_r_valid,
    output logic [DATA_WIDTH-1:0]   tcdm_r_rdata,
    input  logic                    sram_ready_i,
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [SRAM_AW-1:0]      sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] sram_be_o,
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i,
    output logic                    oor_o
);

    typedef struct packed {
        logic                  valid;
        logic                  is_read;
        logic [DATA_WIDTH-1:0] rdata;
    } stage_t;

    logic   gnt;
    logic   unused_add;
    stage_t resp;

    if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX || ADDR_WIDTH <= SRAM_AW + 2) begin : g_bad_cfg
        $error("tcdm_sram_bridge: illegal RD_LATENCY or address widths");
    end

    assign gnt          = tcdm_req & sram_ready_i;
    assign tcdm_gnt     = gnt;
    assign sram_req_o   = gnt;
    assign sram_we_o    = gnt & ~tcdm_wen;
    assign sram_addr_o  = gnt ? tcdm_add[SRAM_AW+1:2] : '0;
    assign sram_wdata_o = gnt ? tcdm_wdata : '0;
    assign sram_be_o    = gnt ? tcdm_be : '0;
    // Byte offset within a word is irrelevant to a word-addressed macro.
    assign unused_add   = ^tcdm_add[1:0];

    // Out-of-range accesses still execute on the truncated address; only flagged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) oor_o <= 1'b0;
        else if (gnt && |tcdm_add[ADDR_WIDTH-1:SRAM_AW+2]) oor_o <= 1'b1;
    end

    tcdm_resp_pipe #(
        .DEPTH   (RD_LATENCY),
        .stage_t (stage_t)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .acc_valid (gnt),
        .acc_read  (tcdm_wen),
        .rdata     (sram_rdata_i),
        .resp      (resp)
    );

    assign tcdm_r_valid = resp.valid;

`ifdef TCDM_SRAM_BRIDGE_RDATA_HOLD_EN
    logic [DATA_WIDTH-1:0] hold_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hold_q <= '0;
        else if (resp.is_read) hold_q <= resp.rdata;
    end
    assign tcdm_r_rdata = resp.is_read ? resp.rdata : hold_q;
`else
    // The pipe already zeroes data for writes and empty slots.
    assign tcdm_r_rdata = resp.rdata;
`endif

endmodule
